// File: rtl/segasys1_pkg.sv
// Shared types and constants for the System 1 hiscore/debug RAM access controller.
package segasys1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } hs_state_t;

  // Channel roles in the default tag table
  localparam int CH_MAIN = 0;
  localparam int CH_VRAM = 1;
  localparam int CH_SPR  = 2;
  localparam int CH_PAL  = 3;

  // Packed tag table, ch0 in the least significant nibble
  localparam logic [15:0] CH_TAG_DFLT = {4'hD, 4'hE, 4'h8, 4'hC};

  function automatic int sel_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/segasys1_hs_decode.sv
// Priority tag decoder: maps the host address tag to a target channel index.
module segasys1_hs_decode #(
  parameter int                   NCH     = 4,
  parameter int                   TAGW    = 4,
  parameter logic [NCH*TAGW-1:0]  CH_TAG  = '0,
  parameter int                   DFLT_CH = 1,
  parameter int                   SELW    = 2
) (
  input  logic [TAGW-1:0] tag,
  output logic [SELW-1:0] sel
);

  // Scanning from the top down lets the lowest matching index win.
  always_comb begin
    sel = SELW'(DFLT_CH);
    for (int i = NCH - 1; i >= 0; i--) begin
      if (CH_TAG[i*TAGW +: TAGW] == tag) sel = SELW'(i);
    end
  end

endmodule

// File: rtl/segasys1_hsbus.sv
// Hiscore/debug RAM access controller: decodes a host access onto one of NCH
// target RAM ports, runs it through a req/ack handshake and absorbs read latency.
module segasys1_hsbus
  import segasys1_pkg::*;
#(
  parameter int                   NCH     = 4,
  parameter int                   AW      = 16,
  parameter int                   DW      = 8,
  parameter int                   TAGW    = 4,
  parameter logic [NCH*TAGW-1:0]  CH_TAG  = (NCH*TAGW)'(CH_TAG_DFLT),
  parameter int                   DFLT_CH = CH_VRAM,
  parameter int                   RD_LAT  = 1,
  parameter bit                   RUN_OK  = 1'b0
) (
  input  logic              clk48M,
  input  logic              reset,
  input  logic              pause_n,
  input  logic              hs_req,
  input  logic              hs_we,
  input  logic [AW-1:0]     hs_ad,
  input  logic [DW-1:0]     hs_di,
  output logic [DW-1:0]     hs_do,
  output logic              hs_ack,
  output logic              hs_busy,
  output logic [AW-1:0]     ch_ad,
  output logic [DW-1:0]     ch_dw,
  output logic [NCH-1:0]    ch_we,
  output logic [NCH-1:0]    ch_rd,
  input  logic [NCH*DW-1:0] ch_dr
);

  localparam int         SELW      = sel_width(NCH);
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  hs_state_t        state, next_state;
  logic             lat_we;
  logic [AW-1:0]    lat_ad;
  logic [DW-1:0]    lat_di;
  logic [SELW-1:0]  sel, dec_sel;
  logic [NCH-1:0]   sel_oh;
  logic             armed;
  logic [1:0]       wait_cnt;
  logic             accept;
  logic             wait_done;

  segasys1_hs_decode #(
    .NCH     (NCH),
    .TAGW    (TAGW),
    .CH_TAG  (CH_TAG),
    .DFLT_CH (DFLT_CH),
    .SELW    (SELW)
  ) u_decode (
    .tag (hs_ad[AW-1 -: TAGW]),
    .sel (dec_sel)
  );

  assign accept    = (state == ST_IDLE) && hs_req && armed && (!pause_n || RUN_OK);
  assign wait_done = (wait_cnt == WAIT_LAST);
  assign sel_oh    = NCH'(1) << sel;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk48M or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = ST_ISSUE;
      ST_ISSUE: next_state = lat_we ? ST_ACK : ST_WAIT;
      ST_WAIT:  if (wait_done) next_state = ST_ACK;
      ST_ACK:   next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    hs_ack  = 1'b0;
    hs_busy = 1'b0;
    ch_ad   = '0;
    ch_dw   = '0;
    ch_we   = '0;
    ch_rd   = '0;
    case (state)
      ST_ISSUE: begin
        hs_busy = 1'b1;
        ch_ad   = lat_ad;
        ch_dw   = lat_di;
        if (lat_we) ch_we = sel_oh;
        else        ch_rd = sel_oh;
      end
      ST_WAIT: begin
        hs_busy = 1'b1;
        ch_ad   = lat_ad;
        ch_dw   = lat_di;
      end
      ST_ACK: begin
        hs_busy = 1'b1;
        hs_ack  = 1'b1;
        ch_ad   = lat_ad;
        ch_dw   = lat_di;
      end
      default: ;
    endcase
  end

  // NOTE: the request latches are plain registers, not a memory, so they are
  // reset to keep every output at zero straight out of reset.
  always_ff @(posedge clk48M or posedge reset) begin
    if (reset) begin
      lat_we <= 1'b0;
      lat_ad <= '0;
      lat_di <= '0;
      sel    <= '0;
    end else if (accept) begin
      lat_we <= hs_we;
      lat_ad <= hs_ad;
      lat_di <= hs_di;
      sel    <= dec_sel;
    end
  end

  // A request still held after its ack must drop before it can start another.
  always_ff @(posedge clk48M or posedge reset) begin
    if (reset)        armed <= 1'b1;
    else if (accept)  armed <= 1'b0;
    else if (!hs_req) armed <= 1'b1;
  end

  always_ff @(posedge clk48M or posedge reset) begin
    if (reset)                    wait_cnt <= '0;
    else if (state == ST_ISSUE)   wait_cnt <= '0;
    else if (state == ST_WAIT)    wait_cnt <= wait_cnt + 2'd1;
  end

  // Read data lands on the last wait cycle so it is already stable with the ack.
  always_ff @(posedge clk48M or posedge reset) begin
    if (reset)                               hs_do <= '0;
    else if ((state == ST_WAIT) && wait_done) hs_do <= ch_dr[sel*DW +: DW];
  end

endmodule

// File: tb/tb_segasys1_hsbus.sv
// Randomized self-checking bench for segasys1_hsbus against a transaction-level model.
module tb_segasys1_hsbus;

  localparam int NCH     = 4;
  localparam int AW      = 16;
  localparam int DW      = 8;
  localparam int TAGW    = 4;
  localparam int DFLT_CH = 1;
  localparam int RD_LAT  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pause_n = 1'b0;
  logic hs_req = 1'b0;
  logic hs_we = 1'b0;
  logic [AW-1:0] hs_ad = '0;
  logic [DW-1:0] hs_di = '0;
  logic [DW-1:0] hs_do;
  logic hs_ack, hs_busy;
  logic [AW-1:0] ch_ad;
  logic [DW-1:0] ch_dw;
  logic [NCH-1:0] ch_we, ch_rd;
  logic [NCH*DW-1:0] ch_dr;

  int checks = 0;
  int failures = 0;

  // Reference: tag per channel (ch0 first), RAM contents and last read value
  logic [3:0]    tags [NCH];
  logic [DW-1:0] ref_mem [NCH][8];
  logic [DW-1:0] tgt_mem [NCH][8];
  logic [DW-1:0] last_rd = '0;

  int            pipe_ch [RD_LAT];
  logic [DW-1:0] pipe_d  [RD_LAT];
  logic [NCH*DW-1:0] junk;

  segasys1_hsbus #(
    .NCH(NCH), .AW(AW), .DW(DW), .TAGW(TAGW),
    .CH_TAG({4'hD, 4'hE, 4'h8, 4'hC}), .DFLT_CH(DFLT_CH),
    .RD_LAT(RD_LAT), .RUN_OK(1'b0)
  ) dut (
    .clk48M(clk), .reset(reset), .pause_n(pause_n),
    .hs_req(hs_req), .hs_we(hs_we), .hs_ad(hs_ad), .hs_di(hs_di),
    .hs_do(hs_do), .hs_ack(hs_ack), .hs_busy(hs_busy),
    .ch_ad(ch_ad), .ch_dw(ch_dw), .ch_we(ch_we), .ch_rd(ch_rd), .ch_dr(ch_dr)
  );

  always #5 clk = ~clk;

  // Target RAMs: RD_LAT-cycle read pipeline, random junk on every idle lane
  always @(posedge clk) begin
    junk <= (NCH*DW)'($urandom);
    if (reset) begin
      for (int c = 0; c < NCH; c++)
        for (int a = 0; a < 8; a++) tgt_mem[c][a] <= ref_mem[c][a];
      for (int s = 0; s < RD_LAT; s++) pipe_ch[s] <= -1;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (ch_we[c]) tgt_mem[c][ch_ad[2:0]] <= ch_dw;
      pipe_ch[0] <= -1;
      for (int c = 0; c < NCH; c++)
        if (ch_rd[c]) begin
          pipe_ch[0] <= c;
          pipe_d[0]  <= tgt_mem[c][ch_ad[2:0]];
        end
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_ch[s] <= pipe_ch[s-1];
        pipe_d[s]  <= pipe_d[s-1];
      end
    end
  end

  always_comb begin
    ch_dr = junk;
    if (pipe_ch[RD_LAT-1] >= 0) ch_dr[pipe_ch[RD_LAT-1]*DW +: DW] = pipe_d[RD_LAT-1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_decode(input logic [AW-1:0] ad);
    for (int c = 0; c < NCH; c++)
      if (ad[AW-1 -: TAGW] == tags[c]) return c;
    return DFLT_CH;
  endfunction

  // One host transaction; entered in the low clock phase with the DUT idle and armed.
  // Cycle n is observed on the falling edge after the n-th rising edge past accept.
  task automatic run_txn(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] di,
                         input int hold, input bit pause_mid);
    int ch   = ref_decode(ad);
    int lat  = we ? 2 : RD_LAT + 2;
    int ncyc = ((hold > lat) ? hold : lat) + 2;
    logic [NCH-1:0] oh = NCH'(1) << ch;
    logic [DW-1:0] exp_do = last_rd;
    if (we) ref_mem[ch][ad[2:0]] = di;
    else    exp_do = ref_mem[ch][ad[2:0]];
    hs_we = we; hs_ad = ad; hs_di = di; hs_req = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("busy",  32'(hs_busy), 32'(n < lat));
      check("ack",   32'(hs_ack),  32'(n == lat - 1));
      check("ch_we", 32'(ch_we),   32'((n == 0 && we)  ? oh : '0));
      check("ch_rd", 32'(ch_rd),   32'((n == 0 && !we) ? oh : '0));
      check("ch_ad", 32'(ch_ad),   32'((n < lat) ? ad : '0));
      if (n == 0 && we) check("ch_dw", 32'(ch_dw), 32'(di));
      check("hs_do", 32'(hs_do),   32'((n >= lat - 1) ? exp_do : last_rd));
      hs_ad = AW'($urandom);
      hs_di = DW'($urandom);
      hs_we = 1'($urandom);
      if (pause_mid && n == 0) pause_n = 1'b1;
      if (n + 1 >= hold) hs_req = 1'b0;
    end
    last_rd = exp_do;
    pause_n = 1'b0;
  endtask

  initial begin
    logic [3:0] tg;
    int r;
    tags = '{4'hC, 4'h8, 4'hE, 4'hD};
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < 8; a++) ref_mem[c][a] = DW'($urandom);
    ref_mem[1][0] = 8'hA7;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_do",   32'(hs_do),   0);
    check("rst_ack",  32'(hs_ack),  0);
    check("rst_busy", 32'(hs_busy), 0);
    check("rst_ad",   32'(ch_ad),   0);
    check("rst_dw",   32'(ch_dw),   0);
    check("rst_we",   32'(ch_we),   0);
    check("rst_rd",   32'(ch_rd),   0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);

    // Paused write to main RAM, then a read through the default-channel tag 8
    run_txn(1'b1, 16'hC123, 8'h5A, 1, 1'b0);
    run_txn(1'b0, 16'h8010, 8'h00, 1, 1'b0);

    // Game running: request is held off until pause
    pause_n = 1'b1; hs_we = 1'b0; hs_ad = 16'hE005; hs_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("run_busy", 32'(hs_busy), 0);
      check("run_rd",   32'(ch_rd),   0);
      check("run_we",   32'(ch_we),   0);
    end
    pause_n = 1'b0;
    run_txn(1'b0, 16'hE005, 8'h00, 3, 1'b0);

    // Unmatched tag with a long-held request: exactly one ack
    run_txn(1'b0, 16'h1234, 8'h00, 20, 1'b0);

    // Alternating channel reads
    for (int i = 0; i < 4; i++)
      run_txn(1'b0, (i % 2 == 0) ? 16'hC000 : 16'h0000, 8'h00, 1, 1'b0);

    // Reset in the middle of a read wait
    hs_we = 1'b0; hs_ad = 16'hD003; hs_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1; hs_req = 1'b0;
    #1;
    check("mid_rst_do",   32'(hs_do),   0);
    check("mid_rst_ack",  32'(hs_ack),  0);
    check("mid_rst_busy", 32'(hs_busy), 0);
    check("mid_rst_ad",   32'(ch_ad),   0);
    check("mid_rst_rd",   32'(ch_rd),   0);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_ack",  32'(hs_ack),  0);
      check("post_rst_busy", 32'(hs_busy), 0);
      check("post_rst_rd",   32'(ch_rd),   0);
    end

    // Randomized traffic with mid-transaction request drops and pause releases
    for (int i = 0; i < 200; i++) begin
      r  = $urandom_range(0, 4);
      tg = (r < NCH) ? tags[r] : 4'($urandom);
      run_txn(1'($urandom), {tg, 9'($urandom), 3'($urandom)}, DW'($urandom),
              $urandom_range(1, RD_LAT + 5), 1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
